// File: rtl/trng_entropy_arbiter_if.sv
// Word handshake bundle between three entropy sources, the arbiter and the mixer input.
// Each source uses syn/data/ack with an enabled flag, and the consumer side uses the same protocol.
interface trng_entropy_arbiter_if;
    logic        src0_enabled, src1_enabled, src2_enabled;
    logic        src0_syn,     src1_syn,     src2_syn;
    logic [31:0] src0_data,    src1_data,    src2_data;
    logic        src0_ack,     src1_ack,     src2_ack;
    logic        entropy_syn;
    logic [31:0] entropy_data;
    logic [1:0]  entropy_src;
    logic        entropy_ack;

    modport master (
        output src0_enabled, src1_enabled, src2_enabled,
        output src0_syn, src1_syn, src2_syn,
        output src0_data, src1_data, src2_data,
        input  src0_ack, src1_ack, src2_ack,
        input  entropy_syn, entropy_data, entropy_src,
        output entropy_ack
    );

    modport slave (
        input  src0_enabled, src1_enabled, src2_enabled,
        input  src0_syn, src1_syn, src2_syn,
        input  src0_data, src1_data, src2_data,
        output src0_ack, src1_ack, src2_ack,
        output entropy_syn, entropy_data, entropy_src,
        input  entropy_ack
    );
endinterface

// File: rtl/trng_entropy_arbiter.sv
// Round-robin arbiter that funnels three entropy sources into one registered syn/data/ack word.
// It also keeps a delivered-word counter for each source.
module trng_entropy_arbiter (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear_stats,
    trng_entropy_arbiter_if.slave   bus,
    output logic [31:0]             src0_words,
    output logic [31:0]             src1_words,
    output logic [31:0]             src2_words
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state, state_nxt;
    logic [1:0]       rr_ptr, rr_nxt;
    logic [1:0]       src_reg;
    logic [31:0]      data_reg;
    logic [2:0]       ack_reg;
    logic [2:0]       cand;
    logic [2:0][31:0] data_v;
    logic             gnt_any, gnt;
    logic [1:0]       gnt_idx;
    logic [2:0][31:0] words_q, words_nxt;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] t;
        t = (v >= 3'd3) ? v - 3'd3 : v;
        return t[1:0];
    endfunction

    assign cand   = {bus.src2_enabled & bus.src2_syn,
                     bus.src1_enabled & bus.src1_syn,
                     bus.src0_enabled & bus.src0_syn} & {3{enable}};
    assign data_v = {bus.src2_data, bus.src1_data, bus.src0_data};

    // Walk offsets from farthest to nearest so the first candidate at/after rr_ptr wins.
    always_comb begin
        logic [1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = rr_ptr;
        idx     = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            idx = wrap3({1'b0, rr_ptr} + 3'(i));
            if (cand[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        gnt       = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    gnt       = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A consumer ack wins over a same-cycle disable: the word is delivered.
                if (bus.entropy_ack) begin
                    state_nxt = IDLE;
                    rr_nxt    = wrap3({1'b0, src_reg} + 3'd1);
                end else if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        words_nxt = words_q;
        for (int n = 0; n < 3; n++) begin
            if (clear_stats)                   words_nxt[n] = 32'd0;
            else if (gnt && gnt_idx == 2'(n))  words_nxt[n] = words_q[n] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= 2'd0;
            data_reg <= 32'd0;
            src_reg  <= 2'd0;
            ack_reg  <= 3'd0;
            words_q  <= '0;
        end else begin
            rr_ptr  <= rr_nxt;
            ack_reg <= gnt ? (3'b001 << gnt_idx) : 3'b000;
            words_q <= words_nxt;
            if (gnt) begin
                data_reg <= data_v[gnt_idx];
                src_reg  <= gnt_idx;
            end
        end
    end

    assign bus.entropy_syn  = (state == HOLD);
    assign bus.entropy_data = data_reg;
    assign bus.entropy_src  = src_reg;
    assign bus.src0_ack     = ack_reg[0];
    assign bus.src1_ack     = ack_reg[1];
    assign bus.src2_ack     = ack_reg[2];
    assign src0_words       = words_q[0];
    assign src1_words       = words_q[1];
    assign src2_words       = words_q[2];
endmodule

// File: tb/tb_trng_entropy_arbiter.sv
// Scoreboard bench for trng_entropy_arbiter: each expected grant is queued as it is provoked.
// A negedge monitor pops and compares it on every source ack pulse.
module tb_trng_entropy_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear_stats = 1'b0;
    logic [31:0] src0_words, src1_words, src2_words;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'ha5a5_a5a5;
    localparam logic [31:0] D2 = 32'h2222_2222;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_ack = -1;
    bit   gap_on = 1'b0;

    trng_entropy_arbiter_if bus();

    trng_entropy_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear_stats (clear_stats),
        .bus         (bus),
        .src0_words  (src0_words),
        .src1_words  (src1_words),
        .src2_words  (src2_words)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] acks();
        return {bus.src2_ack, bus.src1_ack, bus.src0_ack};
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (acks() != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexp_ack", 64'(acks()), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_vec",  64'(acks()), 64'(3'b001 << e.src));
                chk("ent_syn",  64'(bus.entropy_syn), 64'd1);
                chk("ent_src",  64'(bus.entropy_src), 64'(e.src));
                chk("ent_data", 64'(bus.entropy_data), 64'(e.data));
                if (gap_on && last_ack >= 0) chk("ack_gap", 64'(cyc - last_ack), 64'd2);
                last_ack = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_syn(input logic [2:0] s);
        bus.src0_syn = s[0];
        bus.src1_syn = s[1];
        bus.src2_syn = s[2];
    endtask

    task automatic push(input int s);
        exp_t e;
        e.src  = 2'(s);
        e.data = (s == 0) ? D0 : (s == 1) ? D1 : D2;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic chk_words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        chk("words0", 64'(src0_words), 64'(w0));
        chk("words1", 64'(src1_words), 64'(w1));
        chk("words2", 64'(src2_words), 64'(w2));
    endtask

    task automatic chk_reset_outs();
        chk("rst_syn",  64'(bus.entropy_syn), 64'd0);
        chk("rst_data", 64'(bus.entropy_data), 64'd0);
        chk("rst_src",  64'(bus.entropy_src), 64'd0);
        chk("rst_acks", 64'(acks()), 64'd0);
        chk_words(32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        bus.src0_enabled = 1'b1; bus.src1_enabled = 1'b1; bus.src2_enabled = 1'b1;
        bus.src0_data = D0; bus.src1_data = D1; bus.src2_data = D2;
        bus.entropy_ack = 1'b0;
        set_syn(3'b000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs();
        tick();
        reset_n = 1'b1;
        enable  = 1'b1;

        // Single source at full rate
        bus.entropy_ack = 1'b1;
        gap_on = 1'b1; last_ack = -1;
        set_syn(3'b010);
        repeat (4) push(1);
        wait_empty(40);
        tick();
        set_syn(3'b000);
        gap_on = 1'b0;
        repeat (3) tick();
        chk_words(32'd0, 32'd4, 32'd0);

        // All three busy from a fresh reset: strict 0,1,2 rotation
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_syn(3'b111);
        for (int i = 0; i < 6; i++) push(i % 3);
        wait_empty(60);
        tick();
        set_syn(3'b000);
        repeat (2) tick();
        chk_words(32'd2, 32'd2, 32'd2);

        // Consumer stall: word held stable, no new grant until after release
        bus.entropy_ack = 1'b0;
        set_syn(3'b111);
        push(0);
        wait_empty(10);
        repeat (5) begin
            tick();
            @(negedge clk);
            chk("stall_syn",  64'(bus.entropy_syn), 64'd1);
            chk("stall_data", 64'(bus.entropy_data), 64'(D0));
            chk("stall_src",  64'(bus.entropy_src), 64'd0);
        end
        tick();
        bus.entropy_ack = 1'b1;
        push(1);
        @(posedge clk);
        @(negedge clk);
        chk("rel_syn",  64'(bus.entropy_syn), 64'd0);
        chk("rel_acks", 64'(acks()), 64'd0);
        @(negedge clk);
        #1;
        chk("rel_grant", 64'(exp_q.size()), 64'd0);
        tick();
        set_syn(3'b000);
        repeat (2) tick();

        // Disable mid-HOLD discards the word and keeps rr_ptr
        bus.entropy_ack = 1'b0;
        set_syn(3'b111);
        push(2);
        wait_empty(10);
        tick();
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("dis_syn", 64'(bus.entropy_syn), 64'd0);
        tick();
        tick();
        chk("dis_idle", 64'(bus.entropy_syn), 64'd0);
        push(2);
        enable = 1'b1;
        wait_empty(10);
        tick();
        bus.entropy_ack = 1'b1;
        set_syn(3'b000);
        repeat (2) tick();
        chk_words(32'd3, 32'd3, 32'd4);

        // Counter wrap on src2
        @(negedge clk);
        force dut.words_q = {32'hffff_ffff, 32'd3, 32'd3};
        @(posedge clk);
        @(negedge clk);
        release dut.words_q;
        #1;
        chk("pre_wrap", 64'(src2_words), 64'hffff_ffff);
        tick();
        set_syn(3'b100);
        push(2);
        wait_empty(10);
        tick();
        set_syn(3'b000);
        repeat (2) tick();
        chk_words(32'd3, 32'd3, 32'd0);

        // clear_stats on the grant edge beats the increment
        set_syn(3'b001);
        clear_stats = 1'b1;
        push(0);
        tick();
        clear_stats = 1'b0;
        wait_empty(10);
        tick();
        set_syn(3'b000);
        repeat (2) tick();
        chk_words(32'd0, 32'd0, 32'd0);

        // Async reset while holding a word
        bus.entropy_ack = 1'b0;
        set_syn(3'b111);
        push(1);
        wait_empty(10);
        tick();
        reset_n = 1'b0;
        #1;
        chk_reset_outs();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_hold_acks", 64'(acks()), 64'd0);
        tick();
        reset_n = 1'b1;
        bus.entropy_ack = 1'b1;
        push(0); push(1); push(2);
        wait_empty(30);
        tick();
        set_syn(3'b000);
        repeat (2) tick();
        chk_words(32'd1, 32'd1, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
